// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the switch conditioner: interrupt FSM state
// encodings, default timing constants and a constant-width helper.
package switch_defs;

  // Interrupt handshake states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVICED = 2'd2
  } irq_state_e;

  // Default synchroniser depth and debounce period.
  // Boards use a debounce period of about 1000000 cycles.
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Ceiling log2. The result is never below 1, so a counter sized with it
  // always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter and stable value.
// toggle pulses combinationally on the edge where the stable value flips,
// so the parent can record the change on that same edge.
module debounce_bit
  import switch_defs::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic toggle
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // Shift the raw pin into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Count consecutive cycles of disagreement; any agreement restarts the
  // count, so bounces shorter than the debounce period never get through.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    toggle   = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
      toggle   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Switch input stage for the Picoblaze port: per-bit debouncers, sticky
// change flags and an interrupt request/acknowledge handshake.
module switch_conditioner
  import switch_defs::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic [WIDTH-1:0] SWITCHES_IN,
  output logic [WIDTH-1:0] SWITCHES_OUT,
  output logic [WIDTH-1:0] CHANGED,
  input  logic             INT_ENABLE,
  output logic             INTERRUPT,
  input  logic             INTERRUPT_ACK,
  input  logic             CLEAR_STROBE
);

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  irq_state_e       state_q;
  irq_state_e       state_d;
  logic             interrupt_q;
  logic             interrupt_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (CLK_IN),
      .rst    (RESET_IN),
      .din    (SWITCHES_IN[gi]),
      .stable (SWITCHES_OUT[gi]),
      .toggle (toggle[gi])
    );
  end

  assign CHANGED   = changed_q;
  assign INTERRUPT = interrupt_q;

  // Sticky change flags: a toggle on the same edge as a clear wins.
  always_comb begin
    changed_d = changed_q;
    if (CLEAR_STROBE) begin
      changed_d = '0;
    end
    changed_d = changed_d | toggle;
  end

  // Interrupt handshake next state; the request line follows PENDING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (INT_ENABLE && (|changed_q)) state_d = PENDING;
      PENDING:  if (INTERRUPT_ACK)              state_d = SERVICED;
      SERVICED: if (CLEAR_STROBE)               state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
    interrupt_d = (state_d == PENDING);
  end

  // Flag, state and request registers, cleared immediately by reset.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      changed_q   <= '0;
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
    end else begin
      changed_q   <= changed_d;
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
    end
  end

endmodule
